// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the address-split widths, the default line width, the FSM state
// encoding and the per-line metadata payload exchanged with dcache_sram.
package dcache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned OFFSET_W  = 5;   // byte offset within a line
    localparam int unsigned WSEL_W    = 3;   // word select, addr[4:2]
    localparam int unsigned INDEX_W   = 4;   // line index, addr[8:5]
    localparam int unsigned TAG_W     = 23;  // tag, addr[31:9]

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    // Per-line metadata: valid, dirty and stored tag.
    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

endpackage

// File: rtl/dcache_sram.sv
// Cache storage: valid/dirty/tag/data arrays behind a single read/write port.
// Ports:
//   clk_i, rst_i   clock, async active-low reset (clears valid and dirty only)
//   idx_i          line index for both read and write
//   we_i           write metadata and data of line idx_i at the rising edge
//   meta_i/data_i  write payload
//   meta_o/data_o  asynchronous read of line idx_i
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned LINE_BITS = dcache_pkg::LINE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INDEX_W-1:0]   idx_i,
    input  logic                 we_i,
    input  line_meta_t           meta_i,
    input  logic [LINE_BITS-1:0] data_i,
    output line_meta_t           meta_o,
    output logic [LINE_BITS-1:0] data_o
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // Valid and dirty bits are cleared by reset; tags and data are not.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= meta_i.valid;
            dirty_q[idx_i] <= meta_i.dirty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i]  <= meta_i.tag;
            data_q[idx_i] <= data_i;
        end
    end

    always_comb begin
        meta_o.valid = valid_q[idx_i];
        meta_o.dirty = dirty_q[idx_i];
        meta_o.tag   = tag_q[idx_i];
        data_o       = data_q[idx_i];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk_i, rst_i                      clock, async active-low reset
//   cpu_req_i/cpu_write_i             MEM-stage access, 1 = store
//   cpu_addr_i/cpu_data_i             word address and store data
//   cpu_data_o                        load data (zero-latency on a hit)
//   cpu_stall_o                       pipeline freeze on miss
//   mem_enable_o/mem_write_o          line request to memory, 1 = write-back
//   mem_addr_o/mem_data_o             line-aligned address, victim line
//   mem_data_i/mem_ack_i              fetched line, one-cycle completion pulse
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned LINE_BITS = dcache_pkg::LINE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_data_i,
    output logic [WORD_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int unsigned WORDS = LINE_BITS / WORD_W;

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;

    logic [TAG_W-1:0]     cpu_tag;
    logic [INDEX_W-1:0]   cpu_idx;
    logic [WSEL_W-1:0]    cpu_wsel;
    logic [INDEX_W-1:0]   sram_idx;
    line_meta_t           rd_meta, wr_meta;
    logic [LINE_BITS-1:0] rd_data, wr_data, hit_line;
    logic [WORD_W-1:0]    rd_word;
    logic                 sram_we;
    logic                 hit;
    logic                 unused_addr_lsb;

    assign cpu_tag         = cpu_addr_i[31:9];
    assign cpu_idx         = cpu_addr_i[8:5];
    assign cpu_wsel        = cpu_addr_i[4:2];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // While a miss is outstanding the array is addressed by the latched index.
    assign sram_idx = (state_q == ST_IDLE) ? cpu_idx : idx_q;
    assign hit      = rd_meta.valid && (rd_meta.tag == cpu_tag);

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS)
    ) u_sram (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .idx_i  (sram_idx),
        .we_i   (sram_we),
        .meta_i (wr_meta),
        .data_i (wr_data),
        .meta_o (rd_meta),
        .data_o (rd_data)
    );

    // Word select for loads and word merge for stores.
    always_comb begin
        rd_word  = '0;
        hit_line = rd_data;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (WSEL_W'(w) == cpu_wsel) begin
                rd_word                       = rd_data[w*WORD_W +: WORD_W];
                hit_line[w*WORD_W +: WORD_W]  = cpu_data_i;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        sram_we      = 1'b0;
        wr_meta      = '0;
        wr_data      = rd_data;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_write_i) begin
                            sram_we = 1'b1;
                            wr_meta = '{valid: 1'b1, dirty: 1'b1, tag: rd_meta.tag};
                            wr_data = hit_line;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        tag_d       = cpu_tag;
                        idx_d       = cpu_idx;
                        state_d     = (rd_meta.valid && rd_meta.dirty) ? ST_WRITEBACK
                                                                       : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_meta.tag, idx_q, OFFSET_W'(0)};
                mem_data_o   = rd_data;
                if (mem_ack_i) begin
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag_q, idx_q, OFFSET_W'(0)};
                if (mem_ack_i) begin
                    sram_we = 1'b1;
                    wr_meta = '{valid: 1'b1, dirty: 1'b0, tag: tag_q};
                    wr_data = mem_data_i;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller. The reference treats the cache
// as transparent: loads must return the latest value of a flat word memory,
// hits/misses follow a valid/tag/dirty table per index, and every write-back
// must carry the up-to-date contents of the evicted line.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_write_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_controller #(.NUM_LINES(16), .LINE_BITS(256)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state.
    logic [31:0]  ref_mem [logic [29:0]];   // flat word memory as the CPU sees it
    logic [255:0] bk      [logic [26:0]];   // backing memory lines
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [22:0]  m_tag   [16];

    // Responder control.
    bit resp_on    = 1'b1;
    bit inject_ack = 1'b0;
    int fix_lat    = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_word({a[31:2], 2'b00});
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (bk.exists(la[31:5])) return bk[la[31:5]];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la[31:5], 3'(w), 2'b00});
        return l;
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word({la[31:5], 3'(w), 2'b00});
        return l;
    endfunction

    // Memory responder: acks in the Nth cycle mem_enable_o is seen high.
    initial begin
        int rcnt;
        int rlat;
        rcnt = 0;
        rlat = 1;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                rcnt      = 0;
            end
            if (inject_ack) begin
                mem_ack_i  = 1'b1;
                inject_ack = 1'b0;
            end else if (resp_on && rst_i && mem_enable_o) begin
                if (rcnt == 0) rlat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 5));
                rcnt++;
                if (rcnt == rlat) begin
                    mem_ack_i = 1'b1;
                    if (mem_write_o) bk[mem_addr_o[31:5]] = mem_data_o;
                    else mem_data_i = get_line(mem_addr_o);
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // One CPU access, held until it completes; checks every cycle it spans.
    // Entered and left at a falling edge.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls, output int wbs, output logic [31:0] wba,
                          output logic [255:0] wbd, output logic [31:0] rdata);
        int          idx;
        int          phase;
        int          guard;
        logic [22:0] tg;
        logic [31:0] vaddr, naddr;
        idx    = int'(addr[8:5]);
        tg     = addr[31:9];
        stalls = 0;
        wbs    = 0;
        wba    = '0;
        wbd    = '0;
        rdata  = '0;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = wd;
        #1;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            chk("miss_stall", cpu_stall_o, 1'b1);
            chk("miss_idle_men", mem_enable_o, 1'b0);
            if (cpu_stall_o) stalls++;
            vaddr = {m_tag[idx], 4'(idx), 5'b0};
            naddr = {tg, 4'(idx), 5'b0};
            phase = (m_valid[idx] && m_dirty[idx]) ? 1 : 2;
            guard = 0;
            while (phase != 0 && guard < 100) begin
                @(negedge clk_i); #1;
                guard++;
                if (cpu_stall_o) stalls++;
                chk("ph_stall", cpu_stall_o, 1'b1);
                chk("ph_men", mem_enable_o, 1'b1);
                chk("ph_mwr", mem_write_o, phase == 1);
                chk("ph_maddr", mem_addr_o, (phase == 1) ? vaddr : naddr);
                if (mem_ack_i) begin
                    if (phase == 1) begin
                        wbs++;
                        wba = mem_addr_o;
                        wbd = mem_data_o;
                        chk("wb_line", mem_data_o, ref_line(vaddr));
                        phase = 2;
                    end else begin
                        phase = 0;
                    end
                end
            end
            if (phase != 0) begin
                n_checks++;
                $display("FAIL miss_timeout: got no completion expected ack within 100 cycles");
                return;
            end
            @(negedge clk_i); #1;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        chk("hit_stall", cpu_stall_o, 1'b0);
        chk("hit_men", mem_enable_o, 1'b0);
        if (cpu_stall_o) stalls++;
        if (!wr) begin
            rdata = cpu_data_o;
            chk("load_data", cpu_data_o, ref_word(addr));
        end else begin
            ref_mem[addr[31:2]] = wd;
            m_dirty[idx]        = 1'b1;
        end
        @(negedge clk_i);
    endtask

    initial begin
        int           st, wb;
        logic [31:0]  wa, rd;
        logic [255:0] wdat;
        logic [255:0] l0;
        logic [22:0]  tg;
        int           tsel;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end

        // Reset values.
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_men", mem_enable_o, 1'b0);
        chk("rst_mwr", mem_write_o, 1'b0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_cdata", cpu_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // First load at 0x000: line word0 = 5, ack in the 10th memory cycle.
        l0 = get_line(32'h0);
        l0[31:0] = 32'd5;
        bk[27'd0]      = l0;
        ref_mem[30'd0] = 32'd5;
        fix_lat = 10;
        access(1'b0, 32'h0000_0000, 32'h0, st, wb, wa, wdat, rd);
        chk("first_load_stalls", st, 11);
        chk("first_load_data", rd, 32'd5);
        fix_lat = 0;

        // Repeat load hits with no stall.
        access(1'b0, 32'h0000_0000, 32'h0, st, wb, wa, wdat, rd);
        chk("repeat_stalls", st, 0);
        chk("repeat_data", rd, 32'd5);

        // Store then load of the same word.
        access(1'b1, 32'h0000_0004, 32'h12, st, wb, wa, wdat, rd);
        chk("store_stalls", st, 0);
        access(1'b0, 32'h0000_0004, 32'h0, st, wb, wa, wdat, rd);
        chk("st_ld_stalls", st, 0);
        chk("st_ld_data", rd, 32'h12);

        // Conflict miss on a dirty line forces a write-back.
        access(1'b0, 32'h0000_0200, 32'h0, st, wb, wa, wdat, rd);
        chk("evict_wbs", wb, 1);
        chk("evict_wbaddr", wa, 32'h0);
        chk("evict_word1", wdat[63:32], 32'h12);

        // Clean miss on an invalid line.
        access(1'b0, 32'h0000_0020, 32'h0, st, wb, wa, wdat, rd);
        chk("clean_wbs", wb, 0);

        // Reset while allocating; a late ack afterwards is ignored.
        resp_on     = 1'b0;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0040;
        #1;
        chk("ra_miss_stall", cpu_stall_o, 1'b1);
        repeat (3) begin
            @(negedge clk_i); #1;
            chk("ra_men", mem_enable_o, 1'b1);
            chk("ra_maddr", mem_addr_o, 32'h40);
        end
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        chk("ra_rst_men", mem_enable_o, 1'b0);
        chk("ra_rst_mwr", mem_write_o, 1'b0);
        chk("ra_rst_stall", cpu_stall_o, 1'b0);
        chk("ra_rst_maddr", mem_addr_o, 32'h0);
        chk("ra_rst_cdata", cpu_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        inject_ack = 1'b1;
        repeat (2) begin
            @(negedge clk_i); #1;
            chk("late_ack_men", mem_enable_o, 1'b0);
            chk("late_ack_stall", cpu_stall_o, 1'b0);
        end
        @(negedge clk_i);
        resp_on = 1'b1;
        access(1'b0, 32'h0000_0004, 32'h0, st, wb, wa, wdat, rd);
        chk("post_rst_miss", st != 0, 1'b1);
        chk("post_rst_data", rd, 32'h12);

        // Randomized traffic over a few tags to provoke conflicts.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                cpu_req_i = 1'b0;
                #1;
                chk("idle_stall", cpu_stall_o, 1'b0);
                chk("idle_men", mem_enable_o, 1'b0);
                @(negedge clk_i);
            end
            tsel = int'($urandom_range(0, 3));
            tg   = (tsel == 3) ? 23'h7F_FFFF : 23'(tsel);
            access(1'($urandom_range(0, 1)),
                   {tg, 4'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
                   $urandom, st, wb, wa, wdat, rd);
        end

        cpu_req_i = 1'b0;
        @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
